decoder_scan_sequencer: RTL and testbench

//  Upstream stage of the parametrized N-to-2^N decoder. Produces a timed sequence of N-bit indices
//  (first..last, with wrap-around) for the decoder's `in` port, so that decoder outputs are scanned
//  one-hot, one line at a time. Each index is held for a programmable dwell time. Used for
//  LED/row scanning and for sweeping select lines.

---
 rtl/decoder_scan_sequencer.sv | 117 +++++++++++
 tb/tb_decoder_scan_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// Index sequencer feeding an N-to-2^N decoder: steps first..last (with wrap) holding each index dwell+1 cycles.
// Optional build macro SCAN_CONTINUOUS_EN: repeat passes forever until stop/rst instead of finishing once.
module decoder_scan_sequencer #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [N-1:0]       first,
  input  logic [N-1:0]       last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N-1:0]       idx_out,
  output logic               idx_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  localparam logic [N-1:0]       IDX_MAX  = {N{1'b1}};
  localparam logic [N-1:0]       IDX_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] DCNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [N-1:0]       idx_d;
  logic [N-1:0]       first_q, first_d;
  logic [N-1:0]       last_q, last_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               wrap_d, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_out <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      wrap    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_out <= idx_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      dcnt_q  <= dcnt_d;
      wrap    <= wrap_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_out;
    first_d = first_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    dcnt_d  = dcnt_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          idx_d   = first;
          dcnt_d  = dwell;
          first_d = first;
          last_d  = last;
          dwell_d = dwell;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DCNT_ONE;
        end else if (idx_out != last_q) begin
          idx_d  = idx_out + IDX_ONE;
          dcnt_d = dwell_q;
          wrap_d = (idx_out == IDX_MAX);
        end else begin
`ifdef SCAN_CONTINUOUS_EN
          // Restart the pass in place; a reload from 2^N-1 to 0 still counts as a wrap.
          idx_d  = first_q;
          dcnt_d = dwell_q;
          done_d = 1'b1;
          wrap_d = (idx_out == IDX_MAX) && (first_q == '0);
`else
          state_d = DONE_S;
          done_d  = 1'b1;
`endif
        end
      end
      DONE_S: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign idx_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: vector table of scans plus hand-written corner sequences.
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [2:0] first, last;
  logic [7:0] dwell;
  logic [2:0] idx_out;
  logic       idx_valid, busy, wrap, done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  decoder_scan_sequencer #(.N(3), .DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .first(first), .last(last), .dwell(dwell),
    .idx_out(idx_out), .idx_valid(idx_valid), .busy(busy),
    .wrap(wrap), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] first;
    logic [2:0] last;
    logic [7:0] dwell;
    int         run_cycles;
    int         wrap_at;     // run cycle where idx_out first shows 0 after 7, -1 if never
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] f, input logic [2:0] l, input logic [7:0] d);
    first = f; last = l; dwell = d; start = 1'b1;
    step();
    start = 1'b0;
    // Scramble the scan inputs: they must have no effect until the next start.
    first = 3'($urandom_range(0, 7));
    last  = 3'($urandom_range(0, 7));
    dwell = 8'($urandom_range(0, 9));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, idx_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 3'd7, 8'd0, 8,  -1};
    vecs[1] = '{3'd6, 3'd1, 8'd2, 12,  6};
    vecs[2] = '{3'd4, 3'd4, 8'd5, 6,  -1};
    vecs[3] = '{3'd3, 3'd3, 8'd0, 1,  -1};
    vecs[4] = '{3'd7, 3'd0, 8'd1, 4,   2};
    vecs[5] = '{3'd5, 3'd4, 8'd0, 8,   3};

    rst = 1'b1; start = 1'b0; stop = 1'b0; first = '0; last = '0; dwell = '0;
    step(); step();
    chk("rst_idx", idx_out, 0);
    chk("rst_wrap", wrap, 0);
    check_idle("rst");
    rst = 1'b0;
    step();

`ifndef SCAN_CONTINUOUS_EN
    foreach (vecs[v]) begin
      launch(vecs[v].first, vecs[v].last, vecs[v].dwell);
      for (int k = 0; k < vecs[v].run_cycles; k++) begin
        chk($sformatf("v%0d_k%0d_idx", v, k), idx_out,
            int'(3'(vecs[v].first + 3'(k / (vecs[v].dwell + 1)))));
        chk($sformatf("v%0d_k%0d_valid", v, k), idx_valid, 1);
        chk($sformatf("v%0d_k%0d_busy", v, k), busy, 1);
        chk($sformatf("v%0d_k%0d_wrap", v, k), wrap, (k == vecs[v].wrap_at) ? 1 : 0);
        chk($sformatf("v%0d_k%0d_done", v, k), done, 0);
        step();
      end
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_done_valid", v), idx_valid, 0);
      chk($sformatf("v%0d_done_busy", v), busy, 0);
      chk($sformatf("v%0d_done_idx", v), idx_out, int'(vecs[v].last));
      step();
      check_idle($sformatf("v%0d_after", v));
      step();
    end

    // Start pulsed mid-run is ignored: length stays 6 cycles at index 4.
    begin
      int cyc = 0;
      launch(3'd4, 3'd4, 8'd5);
      while (busy && cyc < 20) begin
        if (cyc == 2) begin start = 1'b1; first = 3'd0; end
        else start = 1'b0;
        chk($sformatf("ign_k%0d_idx", cyc), idx_out, 4);
        cyc++;
        step();
      end
      start = 1'b0;
      chk("ign_len", cyc, 6);
      chk("ign_done", done, 1);
      step();
      check_idle("ign_after");
    end
`endif

    // Stop at the 2nd cycle of index 3.
    launch(3'd2, 3'd5, 8'd2);
    for (int k = 0; k < 4; k++) step();
    chk("stop_pre_idx", idx_out, 3);
    chk("stop_pre_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("stop");
    chk("stop_idx", idx_out, 3);
    step();
    chk("stop_later_done", done, 0);
    start = 1'b1; stop = 1'b1; first = 3'd1; last = 3'd2;
    step();
    start = 1'b0; stop = 1'b0;
    check_idle("startstop");
    step();
    chk("startstop_later_busy", busy, 0);

    // Asynchronous reset while idx_out=5.
    launch(3'd2, 3'd7, 8'd0);
    step(); step(); step();
    chk("arst_pre_idx", idx_out, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_idx", idx_out, 0);
    chk("arst_wrap", wrap, 0);
    check_idle("arst");
    @(negedge clk);
    rst = 1'b0;
    step();
    check_idle("arst_after");

`ifdef SCAN_CONTINUOUS_EN
    launch(3'd1, 3'd2, 8'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cont_k%0d_idx", k), idx_out, 1 + (k % 2));
      chk($sformatf("cont_k%0d_valid", k), idx_valid, 1);
      chk($sformatf("cont_k%0d_done", k), done, (k >= 2 && k % 2 == 0) ? 1 : 0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle("cont_stop");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
